flash16_wb_reader: RTL and testbench
====================================

# flash16_wb_reader

Wishbone slave bridging the 32-bit system bus to the board's 16-bit parallel NOR flash (24-bit byte address, `flash_adr`/`flash_d`/`flash_we_n` pins of `system`). Every 32-bit read becomes two timed 16-bit flash reads, assembled big-endian:

- halfword at `adr[1]=0` → `wb_dat_o[31:16]`
- halfword at `adr[1]=1` → `wb_dat_o[15:0]`

The CPU boots the BIOS from flash through this block. Optional halfword programming writes are available for flash update code.

## Interface
Parameters:
- `ADR_WIDTH`, 24: flash byte-address width.
- `RD_TIMING`, 4: cycles each halfword address is held before sampling; legal range 1..15.
- `WR_TIMING`, 6: `flash_we_n` low-pulse length in cycles; legal range 1..15. Used only with the write feature.

Ports (one clock; reset is synchronous and active-low):
- `sys_clk` in 1: system clock; all logic on the rising edge.
- `sys_rst_n` in 1: synchronous, active-low reset.
- `wb_adr_i` in 32: byte address; bits `[ADR_WIDTH-1:2]` used.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte selects.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1 each: Wishbone classic controls.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: one-cycle acknowledge.
- `flash_adr` out `ADR_WIDTH`: byte address; bit 0 always 0.
- `flash_d_i` in 16: flash data input.
- `flash_d_o` out 16: flash data output.
- `flash_d_oe` out 1: data bus drive enable (top-level tristate).
- `flash_oe_n`, `flash_we_n`, `flash_ce_n` out 1 each: flash strobes, active low.

## Operation
- FSM states: IDLE, RD_HI, RD_LO, ACK, WR_SETUP, WR_PULSE, WR_HOLD.
- A 4-bit down-counter `cnt` times each state.
- All outputs are registered.
- **IDLE:**
  - Waits for `wb_cyc_i & wb_stb_i & ~wb_ack_o`.
  - Read: latch `flash_adr = {wb_adr_i[ADR_WIDTH-1:2],2'b00}`, `flash_ce_n=0`, `flash_oe_n=0`, `cnt=RD_TIMING-1`, go to RD_HI.
  - Write: go to WR_SETUP (see Configuration).
- **RD_HI:**
  - When `cnt==0`: capture `flash_d_i` into `wb_dat_o[31:16]`, set `flash_adr[1]=1`, `cnt=RD_TIMING-1`, go to RD_LO.
  - Otherwise decrement `cnt`.
- **RD_LO:**
  - When `cnt==0`: capture `flash_d_i` into `wb_dat_o[15:0]`, assert `wb_ack_o`, deassert `flash_oe_n` and `flash_ce_n`, go to ACK.
- **ACK:**
  - `wb_ack_o` drops; return to IDLE.
  - The ACK cycle guarantees no back-to-back re-trigger on the same strobe.
- **Abort:** `wb_cyc_i` low in any non-IDLE state forces IDLE on the next edge:
  - no ack
  - `flash_oe_n`, `flash_we_n`, `flash_ce_n` = 1
  - `flash_d_oe` = 0
  - `wb_dat_o` keeps any partially captured data
- **Reset mid-operation:** returns to IDLE with reset values. No ack is issued for the interrupted cycle.
- `wb_dat_o` holds its last value between transfers.

## Timing
- Reset values:
  - `wb_ack_o=0`, `wb_dat_o=0`
  - `flash_adr=0`, `flash_d_o=0`, `flash_d_oe=0`
  - `flash_oe_n=1`, `flash_we_n=1`, `flash_ce_n=1`
  - state IDLE
- Read latency: the strobe is sampled at edge E0. `wb_ack_o` is high during the cycle after edge E0+2·RD_TIMING, for exactly one cycle.
  - Example: RD_TIMING=4 gives ack after edge 8.
- Each halfword address is stable for exactly RD_TIMING cycles before its sampling edge.
- Write latency: ack follows edge E0+WR_TIMING+2, i.e. setup 1 + pulse WR_TIMING + hold 1 cycles.
- Minimum spacing from one ack to the next accepted strobe: 1 cycle (the ACK state).

## Configuration
- Macro: `FLASH16_WRITE_EN`.
- **Defined:**
  - `wb_sel_i=4'b1100` programs `wb_dat_i[31:16]` at `adr[1]=0`.
  - `wb_sel_i=4'b0011` programs `wb_dat_i[15:0]` at `adr[1]=1`.
  - Sequence:
    - WR_SETUP: address/data driven, `flash_d_oe=1`, `ce_n=0`, `we_n=1`, `oe_n=1`, 1 cycle.
    - WR_PULSE: `we_n=0`, WR_TIMING cycles.
    - WR_HOLD: `we_n=1`, data still driven, 1 cycle.
    - Then `wb_ack_o`, `flash_d_oe=0`, go to ACK.
  - Any other `wb_sel_i` value on a write: acked one cycle after acceptance, no flash activity.
- **Undefined:**
  - All writes are acked one cycle after acceptance with no flash activity.
  - `flash_d_oe` and `flash_we_n` are constant at their reset values.
  - The WR_* states are not built.

## Test plan
- Reset: `sys_rst_n=0` for 3 cycles → all outputs at their reset values; `flash_we_n=1`, `flash_d_oe=0`.
- Read: flash model returns `0x1234` at byte 0x100 and `0xABCD` at 0x102; read `wb_adr_i=0x100` with RD_TIMING=4 → `wb_dat_o=0x1234ABCD`.
  - ack one cycle, 8 edges after E0.
  - `flash_adr` = 0x100 for 4 cycles, then 0x102.
- Back-to-back reads at 0x0 and 0x4 with the strobe held → two acks separated by exactly 9 cycles; data correct; no duplicate ack.
- Abort: drop `wb_cyc_i` during RD_LO → no ack; strobes high next cycle; next read completes normally.
- Write with `FLASH16_WRITE_EN`: `sel=4'b0011`, `dat=0x0000BEEF`, `adr=0x200`, WR_TIMING=6 →
  - `flash_adr=0x202`, `flash_d_o=0xBEEF`
  - `we_n` low exactly 6 cycles, `flash_d_oe` high 8 cycles
  - ack at E0+8
- Write without the macro, or with `sel=4'b1111` → ack one cycle after acceptance; `flash_we_n` stays 1 throughout.

Source files
------------

// File: rtl/flash16_wb_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : flash16_wb_reader_if
// Description : Wishbone classic bus bundle between the CPU-side master and
//               the flash16_wb_reader slave.
//               master modport : drives wb_adr_i, wb_dat_i, wb_sel_i,
//                                wb_cyc_i, wb_stb_i, wb_we_i
//                                and receives wb_dat_o, wb_ack_o
//               slave modport  : the mirror image
// Revision    : 1.0 - initial release
// ============================================================================
interface flash16_wb_reader_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/flash16_wb_reader.sv
`default_nettype none
// ============================================================================
// Module      : flash16_wb_reader
// Description : Wishbone slave that turns each 32-bit read into two timed
//               16-bit NOR flash reads, assembled big-endian (halfword at
//               adr[1]=0 lands in wb_dat_o[31:16]). Optional halfword
//               programming writes are built when FLASH16_WRITE_EN is defined;
//               otherwise every write is acked one cycle after acceptance
//               with no flash activity.
// Ports       : sys_clk, sys_rst_n  - clock, synchronous active-low reset
//               wb (slave modport)  - Wishbone classic bus
//               flash_adr           - flash byte address (bit 0 always 0)
//               flash_d_i/_o/_oe    - flash data in, data out, drive enable
//               flash_oe_n/we_n/ce_n- flash strobes, active low
// Macro       : FLASH16_WRITE_EN    - enables halfword programming writes
// Revision    : 1.0 - initial release
// ============================================================================
module flash16_wb_reader #(
    parameter int ADR_WIDTH = 24,
    parameter int RD_TIMING = 4,
    parameter int WR_TIMING = 6
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    flash16_wb_reader_if.slave   wb,
    output logic [ADR_WIDTH-1:0] flash_adr,
    input  logic [15:0]          flash_d_i,
    output logic [15:0]          flash_d_o,
    output logic                 flash_d_oe,
    output logic                 flash_oe_n,
    output logic                 flash_we_n,
    output logic                 flash_ce_n
);

    // Elaboration-time range checks on the timing parameters.
    if (RD_TIMING < 1 || RD_TIMING > 15) begin : g_bad_rd_timing
        $error("flash16_wb_reader: RD_TIMING must be 1..15");
    end
    if (WR_TIMING < 1 || WR_TIMING > 15) begin : g_bad_wr_timing
        $error("flash16_wb_reader: WR_TIMING must be 1..15");
    end

    localparam logic [3:0] c_RD_RELOAD = 4'(RD_TIMING - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_HI    = 3'd1,
        ST_RD_LO    = 3'd2,
`ifdef FLASH16_WRITE_EN
        ST_WR_SETUP = 3'd4,
        ST_WR_PULSE = 3'd5,
        ST_WR_HOLD  = 3'd6,
`endif
        ST_ACK      = 3'd3
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_ack;
    logic [31:0]           r_dat;
    logic [ADR_WIDTH-1:0]  r_adr;
    logic                  r_oe_n;
    logic                  r_ce_n;

`ifdef FLASH16_WRITE_EN
    localparam logic [3:0] c_WR_RELOAD = 4'(WR_TIMING - 1);

    logic        r_we_n;
    logic        r_d_oe;
    logic [15:0] r_d_o;

    // Only the two aligned halfword lane patterns reach the flash.
    logic        w_sel_hi;
    logic        w_sel_lo;
    assign w_sel_hi = (wb.wb_sel_i == 4'b1100);
    assign w_sel_lo = (wb.wb_sel_i == 4'b0011);

    assign flash_we_n = r_we_n;
    assign flash_d_oe = r_d_oe;
    assign flash_d_o  = r_d_o;
`else
    assign flash_we_n = 1'b1;
    assign flash_d_oe = 1'b0;
    assign flash_d_o  = 16'h0000;
`endif

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat;
    assign flash_adr   = r_adr;
    assign flash_oe_n  = r_oe_n;
    assign flash_ce_n  = r_ce_n;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_dat   <= 32'h0000_0000;
            r_adr   <= '0;
            r_oe_n  <= 1'b1;
            r_ce_n  <= 1'b1;
`ifdef FLASH16_WRITE_EN
            r_we_n  <= 1'b1;
            r_d_oe  <= 1'b0;
            r_d_o   <= 16'h0000;
`endif
        end else if (r_state != ST_IDLE && !wb.wb_cyc_i) begin
            // Master abandoned the cycle: release the flash, keep any
            // halfword already captured in r_dat.
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_oe_n  <= 1'b1;
            r_ce_n  <= 1'b1;
`ifdef FLASH16_WRITE_EN
            r_we_n  <= 1'b1;
            r_d_oe  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // r_ack is always low here; the term guards re-trigger.
                    if (wb.wb_cyc_i && wb.wb_stb_i && !r_ack) begin
                        if (!wb.wb_we_i) begin
                            r_adr   <= {wb.wb_adr_i[ADR_WIDTH-1:2], 2'b00};
                            r_ce_n  <= 1'b0;
                            r_oe_n  <= 1'b0;
                            r_cnt   <= c_RD_RELOAD;
                            r_state <= ST_RD_HI;
                        end
`ifdef FLASH16_WRITE_EN
                        else if (w_sel_hi || w_sel_lo) begin
                            r_adr   <= {wb.wb_adr_i[ADR_WIDTH-1:2], w_sel_lo, 1'b0};
                            r_d_o   <= w_sel_hi ? wb.wb_dat_i[31:16] : wb.wb_dat_i[15:0];
                            r_d_oe  <= 1'b1;
                            r_ce_n  <= 1'b0;
                            r_we_n  <= 1'b1;
                            r_oe_n  <= 1'b1;
                            r_state <= ST_WR_SETUP;
                        end
`endif
                        else begin
                            // Write with nothing to program: plain ack.
                            r_ack   <= 1'b1;
                            r_state <= ST_ACK;
                        end
                    end
                end

                ST_RD_HI: begin
                    if (r_cnt == 4'd0) begin
                        r_dat[31:16] <= flash_d_i;
                        r_adr[1]     <= 1'b1;
                        r_cnt        <= c_RD_RELOAD;
                        r_state      <= ST_RD_LO;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_RD_LO: begin
                    if (r_cnt == 4'd0) begin
                        r_dat[15:0] <= flash_d_i;
                        r_ack       <= 1'b1;
                        r_oe_n      <= 1'b1;
                        r_ce_n      <= 1'b1;
                        r_state     <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

`ifdef FLASH16_WRITE_EN
                ST_WR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_cnt   <= c_WR_RELOAD;
                    r_state <= ST_WR_PULSE;
                end

                ST_WR_PULSE: begin
                    if (r_cnt == 4'd0) begin
                        r_we_n  <= 1'b1;
                        r_state <= ST_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_WR_HOLD: begin
                    r_ack   <= 1'b1;
                    r_d_oe  <= 1'b0;
                    r_ce_n  <= 1'b1;
                    r_state <= ST_ACK;
                end
`endif

                ST_ACK: begin
                    // One dead cycle so a held strobe is not re-accepted.
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash16_wb_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash16_wb_reader
// Description : Self-checking bench for flash16_wb_reader. A transaction-
//               timeline model predicts every output each cycle; directed
//               literal checks pin latencies, pulse widths and data words.
//               Honours FLASH16_WRITE_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash16_wb_reader;

    localparam int RD = 4;
    localparam int WR = 6;
`ifdef FLASH16_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] flash_adr;
    logic [15:0] flash_d_i;
    logic [15:0] flash_d_o;
    logic        flash_d_oe;
    logic        flash_oe_n;
    logic        flash_we_n;
    logic        flash_ce_n;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    flash16_wb_reader_if wb ();

    flash16_wb_reader #(
        .ADR_WIDTH (24),
        .RD_TIMING (RD),
        .WR_TIMING (WR)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .wb         (wb),
        .flash_adr  (flash_adr),
        .flash_d_i  (flash_d_i),
        .flash_d_o  (flash_d_o),
        .flash_d_oe (flash_d_oe),
        .flash_oe_n (flash_oe_n),
        .flash_we_n (flash_we_n),
        .flash_ce_n (flash_ce_n)
    );

    always #5 clk = ~clk;

    // Flash contents: two fixed words, everything else a simple pattern.
    function automatic logic [15:0] flash_word(input logic [23:0] a);
        if (a == 24'h000100)      return 16'h1234;
        else if (a == 24'h000102) return 16'hABCD;
        else                      return a[15:0] ^ 16'hC3A5;
    endfunction

    assign flash_d_i = flash_word(flash_adr);

    // ---------------- timeline model ----------------
    localparam int K_READ = 0, K_WRITE = 1, K_NULL = 2;

    bit          chk_en = 1'b0;
    bit          m_busy = 1'b0;
    int          m_kind = 0;
    int          m_k    = 0;
    logic [23:0] m_base = '0;
    logic        e_ack  = 1'b0;
    logic [31:0] e_dat  = '0;
    logic [23:0] e_adr  = '0;
    logic [15:0] e_do   = '0;
    logic        e_doe  = 1'b0;
    logic        e_oe_n = 1'b1;
    logic        e_we_n = 1'b1;
    logic        e_ce_n = 1'b1;

    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        if (!rst_n) begin
            m_busy = 1'b0; e_ack = 1'b0; e_dat = '0; e_adr = '0; e_do = '0;
            e_doe = 1'b0; e_oe_n = 1'b1; e_we_n = 1'b1; e_ce_n = 1'b1;
            chk_en = 1'b1;
        end else if (m_busy && !wb.wb_cyc_i) begin
            m_busy = 1'b0; e_ack = 1'b0; e_oe_n = 1'b1; e_we_n = 1'b1;
            e_ce_n = 1'b1; e_doe = 1'b0;
        end else if (m_busy) begin
            m_k = m_k + 1;
            if (m_kind == K_READ) begin
                if (m_k == RD) begin
                    e_dat[31:16] = flash_word(m_base);
                    e_adr = m_base + 24'd2;
                end
                if (m_k == 2*RD) begin
                    e_dat[15:0] = flash_word(m_base + 24'd2);
                    e_ack = 1'b1; e_oe_n = 1'b1; e_ce_n = 1'b1;
                end
                if (m_k == 2*RD + 1) begin
                    e_ack = 1'b0; m_busy = 1'b0;
                end
            end else if (m_kind == K_WRITE) begin
                if (m_k == 1)      e_we_n = 1'b0;
                if (m_k == WR + 1) e_we_n = 1'b1;
                if (m_k == WR + 2) begin
                    e_ack = 1'b1; e_doe = 1'b0; e_ce_n = 1'b1;
                end
                if (m_k == WR + 3) begin
                    e_ack = 1'b0; m_busy = 1'b0;
                end
            end else begin
                e_ack = 1'b0; m_busy = 1'b0;
            end
        end else if (wb.wb_cyc_i && wb.wb_stb_i && !e_ack) begin
            m_busy = 1'b1;
            m_k    = 0;
            if (!wb.wb_we_i) begin
                m_kind = K_READ;
                m_base = {wb.wb_adr_i[23:2], 2'b00};
                e_adr  = m_base;
                e_oe_n = 1'b0; e_ce_n = 1'b0;
            end else if (WR_EN && (wb.wb_sel_i == 4'b1100 || wb.wb_sel_i == 4'b0011)) begin
                m_kind = K_WRITE;
                e_adr  = {wb.wb_adr_i[23:2], (wb.wb_sel_i == 4'b0011), 1'b0};
                e_do   = (wb.wb_sel_i == 4'b1100) ? wb.wb_dat_i[31:16] : wb.wb_dat_i[15:0];
                e_doe  = 1'b1; e_ce_n = 1'b0; e_we_n = 1'b1; e_oe_n = 1'b1;
            end else begin
                m_kind = K_NULL;
                e_ack  = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests = n_tests + 1;
            if (wb.wb_ack_o !== e_ack || wb.wb_dat_o !== e_dat || flash_adr !== e_adr ||
                flash_d_o !== e_do || flash_d_oe !== e_doe || flash_oe_n !== e_oe_n ||
                flash_we_n !== e_we_n || flash_ce_n !== e_ce_n) begin
                n_fail = n_fail + 1;
                $display("FAIL model_cmp edge=%0d got ack=%b dat=%h adr=%h do=%h doe=%b oe_n=%b we_n=%b ce_n=%b want ack=%b dat=%h adr=%h do=%h doe=%b oe_n=%b we_n=%b ce_n=%b",
                         edge_cnt, wb.wb_ack_o, wb.wb_dat_o, flash_adr, flash_d_o, flash_d_oe,
                         flash_oe_n, flash_we_n, flash_ce_n, e_ack, e_dat, e_adr, e_do, e_doe,
                         e_oe_n, e_we_n, e_ce_n);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
    endtask

    // One transaction, started on a fresh negedge, ended on its ack negedge.
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output int lat, output int we_low,
                       output int doe_hi, output int n_a0, output int n_a2);
        int e0;
        @(negedge clk);
        wb.wb_adr_i = adr; wb.wb_dat_i = dat; wb.wb_sel_i = sel;
        wb.wb_we_i = we; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        e0 = edge_cnt + 1;
        lat = -1; we_low = 0; doe_hi = 0; n_a0 = 0; n_a2 = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!flash_we_n) we_low++;
            if (flash_d_oe)  doe_hi++;
            if (!flash_oe_n && flash_adr == {adr[23:2], 2'b00}) n_a0++;
            if (!flash_oe_n && flash_adr == {adr[23:2], 2'b10}) n_a2++;
            if (wb.wb_ack_o) begin
                lat = edge_cnt - e0;
                break;
            end
        end
        if (lat < 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL txn_timeout: got no ack want ack within 60 cycles");
        end
        bus_idle();
    endtask

    // Wait for an ack with a bound; returns cycles spent without ack.
    task automatic wait_ack(input string name, output int gap);
        bit seen;
        seen = 1'b0;
        gap  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wb.wb_ack_o) begin
                seen = 1'b1;
                break;
            end
            gap++;
        end
        if (!seen) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL %s: got no ack want ack within 40 cycles", name);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, we_low, doe_hi, n_a0, n_a2, gap, acks;

        wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
        bus_idle();

        // Reset for 3 cycles
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack",   {31'd0, wb.wb_ack_o}, 32'd0);
        check("rst_dat",   wb.wb_dat_o, 32'h0);
        check("rst_adr",   {8'd0, flash_adr}, 32'h0);
        check("rst_do",    {16'd0, flash_d_o}, 32'h0);
        check("rst_doe",   {31'd0, flash_d_oe}, 32'd0);
        check("rst_oe_n",  {31'd0, flash_oe_n}, 32'd1);
        check("rst_we_n",  {31'd0, flash_we_n}, 32'd1);
        check("rst_ce_n",  {31'd0, flash_ce_n}, 32'd1);
        rst_n = 1'b1;

        // Basic read at 0x100
        txn(1'b0, 32'h100, 32'h0, 4'hF, lat, we_low, doe_hi, n_a0, n_a2);
        check("rd100_dat", wb.wb_dat_o, 32'h1234ABCD);
        check("rd100_lat", lat, 32'd8);
        check("rd100_adr_hi_cycles", n_a0, 32'd4);
        check("rd100_adr_lo_cycles", n_a2, 32'd4);

        // Back-to-back reads with strobe held
        @(negedge clk);
        wb.wb_adr_i = 32'h0; wb.wb_we_i = 1'b0; wb.wb_sel_i = 4'hF;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        wait_ack("b2b_first", gap);
        check("b2b_dat0", wb.wb_dat_o, 32'hC3A5C3A7);
        wb.wb_adr_i = 32'h4;
        wait_ack("b2b_second", gap);
        check("b2b_gap", gap, 32'd9);
        check("b2b_dat4", wb.wb_dat_o, 32'hC3A1C3A3);
        bus_idle();
        acks = 0;
        repeat (12) begin
            @(negedge clk);
            if (wb.wb_ack_o) acks++;
        end
        check("b2b_no_dup_ack", acks, 32'd0);

        // Abort during RD_LO
        @(negedge clk);
        wb.wb_adr_i = 32'h8; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        repeat (6) @(negedge clk);
        bus_idle();
        @(negedge clk);
        check("abort_oe_n", {31'd0, flash_oe_n}, 32'd1);
        check("abort_ce_n", {31'd0, flash_ce_n}, 32'd1);
        check("abort_partial_dat", wb.wb_dat_o, 32'hC3ADC3A3);
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (wb.wb_ack_o) acks++;
        end
        check("abort_no_ack", acks, 32'd0);
        txn(1'b0, 32'h10C, 32'h0, 4'hF, lat, we_low, doe_hi, n_a0, n_a2);
        check("after_abort_dat", wb.wb_dat_o, 32'hC2A9C2AB);
        check("after_abort_lat", lat, 32'd8);

        // Reset in the middle of a read
        @(negedge clk);
        wb.wb_adr_i = 32'h100; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        bus_idle();
        @(negedge clk);
        check("midrst_dat", wb.wb_dat_o, 32'h0);
        check("midrst_oe_n", {31'd0, flash_oe_n}, 32'd1);
        rst_n = 1'b1;
        acks = 0;
        repeat (12) begin
            @(negedge clk);
            if (wb.wb_ack_o) acks++;
        end
        check("midrst_no_ack", acks, 32'd0);
        txn(1'b0, 32'h100, 32'h0, 4'hF, lat, we_low, doe_hi, n_a0, n_a2);
        check("midrst_reread_dat", wb.wb_dat_o, 32'h1234ABCD);

        // Write with sel=1111: never touches the flash
        txn(1'b1, 32'h300, 32'hDEADBEEF, 4'b1111, lat, we_low, doe_hi, n_a0, n_a2);
        check("wr1111_lat", lat, 32'd0);
        check("wr1111_we_low", we_low, 32'd0);
        check("wr1111_doe_hi", doe_hi, 32'd0);

        // Halfword write sel=0011 at 0x200
        txn(1'b1, 32'h200, 32'h0000BEEF, 4'b0011, lat, we_low, doe_hi, n_a0, n_a2);
`ifdef FLASH16_WRITE_EN
        check("wr0011_lat", lat, 32'd8);
        check("wr0011_we_low", we_low, 32'd6);
        check("wr0011_doe_hi", doe_hi, 32'd8);
        check("wr0011_adr", {8'd0, flash_adr}, 32'h202);
        check("wr0011_do", {16'd0, flash_d_o}, 32'hBEEF);
        txn(1'b1, 32'h204, 32'hCAFE0000, 4'b1100, lat, we_low, doe_hi, n_a0, n_a2);
        check("wr1100_lat", lat, 32'd8);
        check("wr1100_adr", {8'd0, flash_adr}, 32'h204);
        check("wr1100_do", {16'd0, flash_d_o}, 32'hCAFE);
`else
        check("wr0011_lat", lat, 32'd0);
        check("wr0011_we_low", we_low, 32'd0);
        check("wr0011_doe_hi", doe_hi, 32'd0);
`endif
        check("dat_held_after_writes", wb.wb_dat_o, 32'h1234ABCD);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
